// File: rtl/bcd_to_ascii_tx.sv
// ---------------------------------------------------------------------------
// bcd_to_ascii_tx
//
// Purpose:
//   Takes one packed-BCD word from the binary-to-BCD stage and streams it out
//   as ASCII characters, most-significant digit first. Leading zeros can be
//   suppressed (a zero word still prints a single '0'). An optional CR LF
//   terminator follows the digits. Every output byte uses a valid/ready
//   handshake. All outputs are registered.
//
// Ports:
//   CLK     in   1         system clock, rising edge
//   RST     in   1         synchronous active-low reset
//   I_DAT   in   4*DIGITS  packed BCD, nibble DIGITS-1 most significant
//   I_STB   in   1         single-cycle strobe qualifying I_DAT
//   O_BUSY  out  1         word in flight; I_STB is ignored while high
//   O_DROP  out  1         one-cycle pulse: a strobe arrived while busy
//   O_DAT   out  8         ASCII byte
//   O_STB   out  1         O_DAT valid
//   I_RDY   in   1         downstream ready; transfer when O_STB & I_RDY
// ---------------------------------------------------------------------------
module bcd_to_ascii_tx #(
    parameter int DIGITS         = 10,
    parameter bit SUPPRESS_ZEROS = 1'b1,
    parameter bit APPEND_CRLF    = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   I_DAT,
    input  logic                  I_STB,
    output logic                  O_BUSY,
    output logic                  O_DROP,
    output logic [7:0]            O_DAT,
    output logic                  O_STB,
    input  logic                  I_RDY
);

    // Digit index must still be at least one bit wide for a single digit.
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DIGIT = 2'd1;
    localparam logic [1:0] ST_CR    = 2'd2;
    localparam logic [1:0] ST_LF    = 2'd3;

    logic [1:0]          state_q;
    logic [1:0]          state_d;
    logic [4*DIGITS-1:0] data_q;
    logic [4*DIGITS-1:0] data_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [IDX_W-1:0]    start_idx;
    logic [3:0]          cur_nib;
    logic [7:0]          char_d;
    logic                xfer;

    // A byte leaves the block when it is presented and the consumer is ready.
    assign xfer = O_STB & I_RDY;

    // Priority encoder for the first printed digit. Scanning upward lets the
    // highest nonzero nibble win; invalid nibbles (A..F) count as nonzero.
    // An all-zero word leaves the index at 0 so a single '0' is printed.
    always_comb begin
        start_idx = '0;
        if (!SUPPRESS_ZEROS) begin
            start_idx = IDX_W'(DIGITS - 1);
        end else begin
            for (int k = 0; k < DIGITS; k++) begin
                if (I_DAT[4*k +: 4] != 4'd0) begin
                    start_idx = IDX_W'(k);
                end
            end
        end
    end

    // Next-state logic. State, index and capture only move on a transfer,
    // which keeps the presented byte frozen under backpressure.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (I_STB) begin
                    data_d  = I_DAT;
                    idx_d   = start_idx;
                    state_d = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                if (xfer) begin
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else begin
                        state_d = APPEND_CRLF ? ST_CR : ST_IDLE;
                    end
                end
            end
            ST_CR: begin
                if (xfer) begin
                    state_d = ST_LF;
                end
            end
            ST_LF: begin
                if (xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Character for the upcoming cycle, derived from the next state so the
    // registered O_DAT lines up with the registered O_STB.
    always_comb begin
        cur_nib = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                cur_nib = data_d[4*k +: 4];
            end
        end

        char_d = 8'h00;
        case (state_d)
            ST_DIGIT: char_d = (cur_nib <= 4'd9) ? (8'h30 | {4'h0, cur_nib}) : 8'h3F;
            ST_CR:    char_d = 8'h0D;
            ST_LF:    char_d = 8'h0A;
            default:  char_d = 8'h00;
        endcase
    end

    // State and output registers. A strobe seen while a word is in flight
    // is discarded and flagged for one cycle; the capture is untouched.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            O_DAT   <= 8'h00;
            O_STB   <= 1'b0;
            O_BUSY  <= 1'b0;
            O_DROP  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            O_DAT   <= char_d;
            O_STB   <= (state_d != ST_IDLE);
            O_BUSY  <= (state_d != ST_IDLE);
            O_DROP  <= I_STB & (state_q != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_bcd_to_ascii_tx.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_ascii_tx
//
// Purpose:
//   Self-checking bench for bcd_to_ascii_tx. Instance dut_a uses the default
//   parameters (suppression on, CR LF on); dut_b disables zero suppression.
//   Each instance has its own strobe so only the selected one is exercised.
//   A table of words with hand-computed byte strings is replayed, followed
//   by a hand-written mid-word reset sequence.
// ---------------------------------------------------------------------------
module tb_bcd_to_ascii_tx;

    logic        clk;
    logic        rst;
    logic [39:0] i_dat;
    logic        i_stb_a;
    logic        i_stb_b;
    logic        i_rdy;

    logic        o_busy_a;
    logic        o_drop_a;
    logic [7:0]  o_dat_a;
    logic        o_stb_a;
    logic        o_busy_b;
    logic        o_drop_b;
    logic [7:0]  o_dat_b;
    logic        o_stb_b;

    int total;
    int bad;

    typedef struct {
        logic        sel;
        logic [39:0] dat;
        int          mode;
        int          drop_at;
        int          n;
        logic [95:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[6];

    bcd_to_ascii_tx #(
        .DIGITS(10), .SUPPRESS_ZEROS(1'b1), .APPEND_CRLF(1'b1)
    ) dut_a (
        .CLK(clk), .RST(rst), .I_DAT(i_dat), .I_STB(i_stb_a),
        .O_BUSY(o_busy_a), .O_DROP(o_drop_a), .O_DAT(o_dat_a),
        .O_STB(o_stb_a), .I_RDY(i_rdy)
    );

    bcd_to_ascii_tx #(
        .DIGITS(10), .SUPPRESS_ZEROS(1'b0), .APPEND_CRLF(1'b1)
    ) dut_b (
        .CLK(clk), .RST(rst), .I_DAT(i_dat), .I_STB(i_stb_b),
        .O_BUSY(o_busy_b), .O_DROP(o_drop_b), .O_DAT(o_dat_b),
        .O_STB(o_stb_b), .I_RDY(i_rdy)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check goes through here.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_stb(input logic sel, input logic v);
        if (sel) i_stb_b = v;
        else     i_stb_a = v;
    endtask

    // Strobe one word into the selected instance and collect its bytes.
    // mode 0: ready always high; mode 1: ready pattern 1,0,0 repeating.
    // drop_at >= 0 injects a second strobe (data 0x99) on that loop cycle.
    // Called at #1 after a rising edge with the instance idle; returns the
    // same way, one cycle after the final transfer.
    task automatic apply_stimulus(input logic sel, input logic [39:0] dat, input int mode,
                                  input int drop_at, input int n, input logic [95:0] exp,
                                  input string name);
        logic [95:0] shifted;
        logic [7:0]  dat_o;
        logic [7:0]  last_dat;
        logic        stb_o;
        logic        busy_o;
        logic        drop_o;
        logic        rdy;
        logic        stalled;
        logic        done;
        int          got;

        got     = 0;
        stalled = 1'b0;
        done    = 1'b0;
        last_dat = 8'h00;

        i_dat = dat;
        i_rdy = 1'b1;
        set_stb(sel, 1'b1);
        @(posedge clk); #1;
        set_stb(sel, 1'b0);

        for (int cyc = 0; cyc < 100; cyc++) begin
            rdy   = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            i_rdy = rdy;
            if (drop_at >= 0 && cyc == drop_at) begin
                i_dat = 40'h0000000099;
                set_stb(sel, 1'b1);
            end else begin
                set_stb(sel, 1'b0);
            end

            stb_o  = sel ? o_stb_b  : o_stb_a;
            dat_o  = sel ? o_dat_b  : o_dat_a;
            busy_o = sel ? o_busy_b : o_busy_a;
            drop_o = sel ? o_drop_b : o_drop_a;

            check_output($sformatf("%s drop c%0d", name, cyc), {31'd0, drop_o},
                         {31'd0, (drop_at >= 0 && cyc == drop_at + 1)});

            if (!stb_o || !busy_o) begin
                total++;
                bad++;
                $display("[TB] FAIL %s valid gap c%0d: stb=%0b busy=%0b expected 1", name, cyc, stb_o, busy_o);
                break;
            end

            if (stalled) begin
                check_output($sformatf("%s hold c%0d", name, cyc), {24'd0, dat_o}, {24'd0, last_dat});
            end

            if (rdy) begin
                shifted = exp << (8 * got);
                check_output($sformatf("%s byte%0d", name, got), {24'd0, dat_o}, {24'd0, shifted[95:88]});
                got++;
                stalled = 1'b0;
            end else begin
                stalled  = 1'b1;
                last_dat = dat_o;
            end

            @(posedge clk); #1;

            if (got == n) begin
                set_stb(sel, 1'b0);
                stb_o  = sel ? o_stb_b  : o_stb_a;
                busy_o = sel ? o_busy_b : o_busy_a;
                check_output({name, " end stb"},  {31'd0, stb_o},  32'd0);
                check_output({name, " end busy"}, {31'd0, busy_o}, 32'd0);
                done = 1'b1;
                break;
            end
        end

        set_stb(sel, 1'b0);
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL %s incomplete: got %0d bytes expected %0d", name, got, n);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        i_dat   = '0;
        i_stb_a = 1'b0;
        i_stb_b = 1'b0;
        i_rdy   = 1'b0;

        vecs[0] = '{1'b0, 40'h0000012345, 0, -1, 7,
                    {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A, 40'h0}, "w12345"};
        vecs[1] = '{1'b0, 40'h0000000000, 0, -1, 3,
                    {8'h30, 8'h0D, 8'h0A, 72'h0}, "zero_sup"};
        vecs[2] = '{1'b1, 40'h0000000000, 0, -1, 12,
                    {{10{8'h30}}, 8'h0D, 8'h0A}, "zero_full"};
        vecs[3] = '{1'b0, 40'h4294967295, 1, -1, 12,
                    {8'h34, 8'h32, 8'h39, 8'h34, 8'h39, 8'h36, 8'h37, 8'h32,
                     8'h39, 8'h35, 8'h0D, 8'h0A}, "bp_max"};
        vecs[4] = '{1'b0, 40'h00000A0709, 0, -1, 7,
                    {8'h3F, 8'h30, 8'h37, 8'h30, 8'h39, 8'h0D, 8'h0A, 40'h0}, "invalid"};
        vecs[5] = '{1'b0, 40'h0000012345, 0, 1, 7,
                    {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h0D, 8'h0A, 40'h0}, "drop"};

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        check_output("rst stb_a",  {31'd0, o_stb_a},  32'd0);
        check_output("rst busy_a", {31'd0, o_busy_a}, 32'd0);
        check_output("rst drop_a", {31'd0, o_drop_a}, 32'd0);
        check_output("rst dat_a",  {24'd0, o_dat_a},  32'd0);
        check_output("rst stb_b",  {31'd0, o_stb_b},  32'd0);
        check_output("rst busy_b", {31'd0, o_busy_b}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v].sel, vecs[v].dat, vecs[v].mode, vecs[v].drop_at,
                           vecs[v].n, vecs[v].exp, vecs[v].name);
        end

        // The dropped word must not start a transfer afterwards.
        repeat (3) @(posedge clk);
        #1;
        check_output("post drop idle", {31'd0, o_stb_a}, 32'd0);

        // Mid-word reset while the third byte is presented.
        i_dat   = 40'h0000012345;
        i_rdy   = 1'b1;
        i_stb_a = 1'b1;
        @(posedge clk); #1;
        i_stb_a = 1'b0;
        check_output("abort b0", {24'd0, o_dat_a}, 32'h31);
        @(posedge clk); #1;
        check_output("abort b1", {24'd0, o_dat_a}, 32'h32);
        @(posedge clk); #1;
        check_output("abort b2", {24'd0, o_dat_a}, 32'h33);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_output("abort stb",  {31'd0, o_stb_a},  32'd0);
        check_output("abort busy", {31'd0, o_busy_a}, 32'd0);
        check_output("abort dat",  {24'd0, o_dat_a},  32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_output("abort quiet", {31'd0, o_stb_a}, 32'd0);

        apply_stimulus(1'b0, 40'h0000000007, 0, -1, 3,
                       {8'h37, 8'h0D, 8'h0A, 72'h0}, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
